// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: synchronous PS/2 keyboard receiver with glitch filter, prefix folding and event FIFO.
// Optional PS2_TYPEMATIC_SUPPRESS_EN drops repeated makes of the currently held key.
module ps2_keyboard_rx #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT_US = 2000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk_100mhz,
    input  logic                          rst,
    input  logic                          ps2_c,
    input  logic                          ps2_d,
    output logic [9:0]                    ev_data,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          frame_err,
    output logic                          overflow
);
    localparam int TO_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int TW     = $clog2(TO_CYC + 1);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int LW     = AW + 1;

    typedef enum logic [1:0] {IDLE, DATA, CHECK} state_t;

    logic [1:0]            c_sync, d_sync;
    logic [FILTER_LEN-1:0] c_sh, d_sh;
    logic                  c_filt, d_filt, c_prev, strobe;
    state_t                state;
    logic [3:0]            bit_cnt;
    logic [9:0]            sh;
    logic [TW-1:0]         to_cnt;
    logic                  ext_pend, brk_pend;
    logic                  good, is_pfx, drop, push, pop, full, wr_en;
    logic [9:0]            ev_new;
    logic [9:0]            mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;

    // Filtered level only moves when the whole window agrees on the opposite value
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            c_sync <= '1;
            d_sync <= '1;
            c_sh   <= '1;
            d_sh   <= '1;
            c_filt <= 1'b1;
            d_filt <= 1'b1;
            c_prev <= 1'b1;
        end else begin
            c_sync <= {c_sync[0], ps2_c};
            d_sync <= {d_sync[0], ps2_d};
            c_sh   <= {c_sh[FILTER_LEN-2:0], c_sync[1]};
            d_sh   <= {d_sh[FILTER_LEN-2:0], d_sync[1]};
            c_filt <= (&c_sh) ? 1'b1 : (~|c_sh) ? 1'b0 : c_filt;
            d_filt <= (&d_sh) ? 1'b1 : (~|d_sh) ? 1'b0 : d_filt;
            c_prev <= c_filt;
        end
    end

    assign strobe = c_prev & ~c_filt;
    assign good   = (^sh[8:0]) & sh[9];
    assign is_pfx = (sh[7:0] == 8'hE0) || (sh[7:0] == 8'hF0);
    assign ev_new = {ext_pend, brk_pend, sh[7:0]};
    assign push   = (state == CHECK) && good && !is_pfx && !drop;

`ifdef PS2_TYPEMATIC_SUPPRESS_EN
    logic       held_v;
    logic [8:0] held;
    assign drop = !brk_pend && held_v && (held == {ext_pend, sh[7:0]});
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            held_v <= 1'b0;
            held   <= '0;
        end else if (state == CHECK && good && !is_pfx) begin
            if (!brk_pend) begin
                held_v <= 1'b1;
                held   <= {ext_pend, sh[7:0]};
            end else if (held_v && held == {ext_pend, sh[7:0]}) begin
                held_v <= 1'b0;
            end
        end
    end
`else
    assign drop = 1'b0;
`endif

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            sh        <= '0;
            to_cnt    <= '0;
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    to_cnt <= '0;
                    if (strobe && !d_filt) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (strobe) begin
                        sh      <= {d_filt, sh[9:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        to_cnt  <= '0;
                        if (bit_cnt == 4'd9) state <= CHECK;
                    end else if (to_cnt == TW'(TO_CYC)) begin
                        frame_err <= 1'b1;
                        ext_pend  <= 1'b0;
                        brk_pend  <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    state <= IDLE;
                    if (!good) begin
                        frame_err <= 1'b1;
                        ext_pend  <= 1'b0;
                        brk_pend  <= 1'b0;
                    end else if (sh[7:0] == 8'hE0) begin
                        ext_pend <= 1'b1;
                    end else if (sh[7:0] == 8'hF0) begin
                        brk_pend <= 1'b1;
                    end else begin
                        ext_pend <= 1'b0;
                        brk_pend <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ev_valid = fifo_level != '0;
    assign ev_data  = ev_valid ? mem[rd_ptr] : '0;
    assign full     = fifo_level == LW'(FIFO_DEPTH);
    assign pop      = ev_valid && ev_ready;
    assign wr_en    = push && (!full || pop);

    always_ff @(posedge clk_100mhz) begin
        if (wr_en) mem[wr_ptr] <= ev_new;
    end

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_level <= fifo_level + LW'(wr_en) - LW'(pop);
            if (push && full && !pop) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb_ps2_keyboard_rx: table-driven frames plus corner-case sequences, events checked via a scoreboard queue.
module tb_ps2_keyboard_rx;
    logic       clk_100mhz = 1'b0;
    logic       rst, ps2_c, ps2_d, ev_ready;
    logic [9:0] ev_data;
    logic       ev_valid, frame_err, overflow;
    logic [3:0] fifo_level;

    int         checks = 0;
    int         failures = 0;
    int         err_cnt = 0;
    int         e0;
    logic [9:0] exp_q[$];

    typedef struct {
        logic [7:0] code;
        logic       bad_par;
        logic       bad_stop;
        logic       exp_err;
        logic       exp_push;
        logic [9:0] exp_ev;
    } vec_t;
    vec_t vecs[15];

    ps2_keyboard_rx #(.CLK_HZ(1_000_000), .FILTER_LEN(8), .TIMEOUT_US(200), .FIFO_DEPTH(8)) dut (
        .clk_100mhz(clk_100mhz), .rst(rst), .ps2_c(ps2_c), .ps2_d(ps2_d),
        .ev_data(ev_data), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .fifo_level(fifo_level), .frame_err(frame_err), .overflow(overflow));

    always #5 clk_100mhz = ~clk_100mhz;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_100mhz);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        ps2_d = b;
        tick(6);
        ps2_c = 1'b0;
        tick(12);
        ps2_c = 1'b1;
        tick(6);
    endtask

    task automatic send_frame(input logic [7:0] code, input logic bad_par, input logic bad_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(code[i]);
        send_bit(~^code ^ bad_par);
        send_bit(~bad_stop);
        ps2_d = 1'b1;
        tick(20);
    endtask

    always @(negedge clk_100mhz) begin
        if (frame_err) err_cnt++;
        if (!rst && ev_valid && ev_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event: got 0x%0h expected none", ev_data);
            end else begin
                check("event", {22'd0, ev_data}, {22'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        vecs[0]  = '{8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 10'h01C};
        vecs[1]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000};
        vecs[2]  = '{8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 10'h11C};
        vecs[3]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000};
        vecs[4]  = '{8'h75, 1'b0, 1'b0, 1'b0, 1'b1, 10'h275};
        vecs[5]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000};
        vecs[6]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000};
        vecs[7]  = '{8'h75, 1'b0, 1'b0, 1'b0, 1'b1, 10'h375};
        vecs[8]  = '{8'h1C, 1'b1, 1'b0, 1'b1, 1'b0, 10'h000};
        vecs[9]  = '{8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 10'h01C};
        vecs[10] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000};
        vecs[11] = '{8'h1D, 1'b0, 1'b1, 1'b1, 1'b0, 10'h000};
        vecs[12] = '{8'h1D, 1'b0, 1'b0, 1'b0, 1'b1, 10'h01D};
        vecs[13] = '{8'hE1, 1'b0, 1'b0, 1'b0, 1'b1, 10'h0E1};
        vecs[14] = '{8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 10'h0AA};

        rst = 1'b1;
        ps2_c = 1'b1;
        ps2_d = 1'b1;
        ev_ready = 1'b1;
        tick(4);
        check("rst_ev_valid", {31'd0, ev_valid}, 0);
        check("rst_ev_data", {22'd0, ev_data}, 0);
        check("rst_fifo_level", {28'd0, fifo_level}, 0);
        check("rst_frame_err", {31'd0, frame_err}, 0);
        check("rst_overflow", {31'd0, overflow}, 0);
        rst = 1'b0;
        tick(30);

        for (int i = 0; i < 15; i++) begin
            e0 = err_cnt;
            if (vecs[i].exp_push) exp_q.push_back(vecs[i].exp_ev);
            send_frame(vecs[i].code, vecs[i].bad_par, vecs[i].bad_stop);
            check($sformatf("vec%0d_frame_err", i), err_cnt - e0, {31'd0, vecs[i].exp_err});
            check($sformatf("vec%0d_drained", i), exp_q.size(), 0);
        end

        e0 = err_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        ps2_d = 1'b1;
        tick(300);
        check("timeout_err", err_cnt - e0, 1);
        exp_q.push_back(10'h01C);
        send_frame(8'h1C, 1'b0, 1'b0);
        check("after_timeout_drained", exp_q.size(), 0);

        e0 = err_cnt;
        ps2_d = 1'b0;
        tick(6);
        ps2_c = 1'b0;
        tick(3);
        ps2_c = 1'b1;
        tick(30);
        ps2_d = 1'b1;
        tick(10);
        check("glitch_no_err", err_cnt - e0, 0);
        exp_q.push_back(10'h02A);
        send_frame(8'h2A, 1'b0, 1'b0);
        check("glitch_next_frame", exp_q.size(), 0);
        check("glitch_no_extra_err", err_cnt - e0, 0);

        check("overflow_clear", {31'd0, overflow}, 0);
        ev_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k < 8) exp_q.push_back(10'(8'h15 + k));
            send_frame(8'(8'h15 + k), 1'b0, 1'b0);
        end
        check("full_level", {28'd0, fifo_level}, 8);
        check("full_overflow", {31'd0, overflow}, 1);
        check("full_valid", {31'd0, ev_valid}, 1);
        check("full_head", {22'd0, ev_data}, 32'h015);
        ev_ready = 1'b1;
        tick(20);
        check("drain_level", {28'd0, fifo_level}, 0);
        check("drain_data_zero", {22'd0, ev_data}, 0);
        check("drain_queue", exp_q.size(), 0);
        check("overflow_sticky", {31'd0, overflow}, 1);

`ifdef PS2_TYPEMATIC_SUPPRESS_EN
        exp_q.push_back(10'h01C);
        exp_q.push_back(10'h11C);
`else
        exp_q.push_back(10'h01C);
        exp_q.push_back(10'h01C);
        exp_q.push_back(10'h01C);
        exp_q.push_back(10'h11C);
`endif
        send_frame(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        tick(20);
        check("typematic_queue", exp_q.size(), 0);
        check("final_level", {28'd0, fifo_level}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
